array_prod: RTL and testbench
=============================

// Module: array_prod
// PURPOSE
//  Sequential fixed-point dot product of two NUM_ELEM-element packed vectors: result = sum(a[i]*b[i]).
//  One multiply-accumulate (MAC) per clock, which maps to one DSP48.
//  Sits after the LSTM layer as the output perceptron: a = output weights, b = hidden-state vector h.
//  The result is in the same signed Q(QN).(QM) format as the inputs.
// PARAMETERS
//  NUM_ELEM  8   number of vector elements (>=1)
//  QN        6   integer bits (excluding sign)
//  QM        11  fractional bits
//  BITWIDTH  QN+QM+1 (localparam, 18)  element/result width, two's complement
// PORTS
//  clock     in   1                  single clock, rising edge
//  reset     in   1                  synchronous, active-low; 0 = clear and hold, 1 = run
//  vecA      in   NUM_ELEM*BITWIDTH  packed vector; element i = vecA[i*BITWIDTH +: BITWIDTH]
//  vecB      in   NUM_ELEM*BITWIDTH  packed vector, same packing
//  dataReady out  1                  high = result valid; held until next reset
//  result    out  BITWIDTH           dot product, signed Q(QN).(QM)
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge): idx=0, acc=0, dataReady=0, result=0. Takes priority over everything, including mid-computation.
//  - States:
//    - RUN: each edge with reset==1, acc += $signed(vecA[idx])*$signed(vecB[idx]) (full 2*BITWIDTH product), idx++.
//    - After element NUM_ELEM-1, go to DONE.
//    - DONE: on the next edge, result <= fmt(acc) and dataReady <= 1.
//    - Remain in DONE with outputs frozen until reset==0. No automatic restart.
//  - Latency: dataReady rises on the (NUM_ELEM+1)th rising edge after the first edge sampling reset==1. For NUM_ELEM=8, that is 9 edges.
//  - Inputs must be stable from reset release until dataReady. Input changes in DONE are ignored.
//  - Accumulator width: 2*BITWIDTH+clog2(NUM_ELEM) bits, signed, never overflows internally.
//  - fmt(acc): arithmetic shift right by QM (truncation toward -inf, no rounding), then reduce to BITWIDTH (see CONFIGURATION).
//  - Single accumulate path; no pipelining beyond the result register.
//  - dataReady is a level, not a pulse. The consumer restarts the block by pulsing reset low for >=1 cycle.
// CONFIGURATION
//  ARRAY_PROD_SATURATE_EN
//    - Defined: shifted sum clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1], i.e. [18'h20000, 18'h1FFFF].
//    - Undefined: result = low BITWIDTH bits of the shifted sum (two's-complement wrap).
//    - Everything else (latency, handshake, reset) is identical in both builds.
// TESTING (NUM_ELEM=8, QN=6, QM=11; 1.0 = 18'h00800)
//  1. All vecA = 1.0 (2048), all vecB = 0.5 (1024), release reset
//     -> dataReady=0 for 8 edges, =1 on edge 9; result = 18'h02000 (4.0).
//  2. vecA = -1.0 (18'h3F800), vecB = 0.25 (512) in all elements
//     -> result = -2.0 = 18'h3F000.
//  3. Truncation: element 0 = (1 LSB, 1 LSB), others 0 -> result 0.
//     Element 0 = (-1 LSB, 1 LSB) -> result 18'h3FFFF (-1 LSB, floor).
//  4. Overflow: all elements 31.0 * 31.0
//     -> with ARRAY_PROD_SATURATE_EN: result 18'h1FFFF; without: 18'h04000 (wrapped).
//  5. Reset low at edge 4 of a computation -> next edge dataReady=0, result=0.
//     After release, full 9-edge latency again with the correct sum.
//  6. In DONE, change vecA/vecB for 10 cycles -> result and dataReady unchanged.
//     reset low -> both cleared the following edge.

Source files
------------

// File: rtl/array_prod.sv
// -----------------------------------------------------------------------------
// array_prod
//   Sequential signed fixed-point dot product, result = sum(vecA[i] * vecB[i]).
//   One multiply-accumulate per clock into a full-precision accumulator.
//   The sum is rescaled to Q(QN).(QM) once, when the result is registered.
//   Used as the output perceptron after the LSTM layer:
//   vecA = output weights, vecB = hidden state.
//
// Build option
//   ARRAY_PROD_SATURATE_EN  defined   : out-of-range results clamp to the
//                                       most negative / most positive value
//                           undefined : out-of-range results wrap
//                                       (two's complement)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low; 0 = clear and hold, 1 = run
//   vecA       in   NUM_ELEM packed elements, element i at [i*BITWIDTH +: BITWIDTH]
//   vecB       in   NUM_ELEM packed elements, same packing
//   dataReady  out  level, high once the result is valid, held until reset
//   result     out  dot product, signed Q(QN).(QM)
//
// state  | meaning
// S_RUN  | one MAC per edge, stepping r_idx through 0 .. NUM_ELEM-1
// S_DONE | accumulation finished; next edge registers result, raises dataReady
// S_HOLD | outputs frozen until reset is asserted
// -----------------------------------------------------------------------------
module array_prod #(
    parameter int NUM_ELEM = 8,
    parameter int QN       = 6,
    parameter int QM       = 11
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_ELEM*(QN+QM+1)-1:0]    vecA,
    input  logic [NUM_ELEM*(QN+QM+1)-1:0]    vecB,
    output logic                             dataReady,
    output logic [QN+QM:0]                   result
);

    localparam int BITWIDTH = QN + QM + 1;
    localparam int CNT_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int ACC_W    = 2 * BITWIDTH + $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DONE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;

    logic signed [BITWIDTH-1:0]   w_a;
    logic signed [BITWIDTH-1:0]   w_b;
    logic signed [2*BITWIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;
    logic [BITWIDTH-1:0]          w_fmt;

    assign w_a        = vecA[int'(r_idx)*BITWIDTH +: BITWIDTH];
    assign w_b        = vecB[int'(r_idx)*BITWIDTH +: BITWIDTH];
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = ACC_W'(w_prod);   // sign-extends: w_prod is signed

`ifdef ARRAY_PROD_SATURATE_EN
    // Bits from the result sign bit upward; in range only if all equal.
    logic [ACC_W-QM-BITWIDTH:0] w_hi;
    assign w_hi = r_acc[ACC_W-1:QM+BITWIDTH-1];
`endif

    // Arithmetic shift right by QM, then keep BITWIDTH bits: that is
    // exactly the slice r_acc[QM +: BITWIDTH] (floor, no rounding).
    always_comb begin
        w_fmt = r_acc[QM +: BITWIDTH];
`ifdef ARRAY_PROD_SATURATE_EN
        if (!(&w_hi) && (|w_hi)) begin
            w_fmt = r_acc[ACC_W-1] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                   : {1'b0, {(BITWIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_idx     <= '0;
            r_acc     <= '0;
            dataReady <= 1'b0;
            result    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx == CNT_W'(NUM_ELEM - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    result    <= w_fmt;
                    dataReady <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    r_state <= S_HOLD;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_prod.sv
module tb_array_prod;

    localparam int N  = 8;
    localparam int BW = 18;

    logic                clock;
    logic                reset;
    logic [N*BW-1:0]     vecA;
    logic [N*BW-1:0]     vecB;
    logic                dataReady;
    logic [BW-1:0]       result;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] exp_q[$];
    string         name_q[$];

    array_prod #(.NUM_ELEM(N), .QN(6), .QM(11)) dut (
        .clock     (clock),
        .reset     (reset),
        .vecA      (vecA),
        .vecB      (vecB),
        .dataReady (dataReady),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compares the result against the scoreboard whenever
    // dataReady rises.
    logic mon_prev = 1'b0;
    always @(negedge clock) begin
        if (dataReady && !mon_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result got %h with nothing expected", result);
            end else begin
                logic [BW-1:0] e;
                string         nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (result !== e) begin
                    n_errors++;
                    $display("FAIL %s result got %h expected %h", nm, result, e);
                end
            end
        end
        mon_prev = dataReady;
    end

    task automatic check(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_all(input logic [BW-1:0] a, input logic [BW-1:0] b);
        for (int i = 0; i < N; i++) begin
            vecA[i*BW +: BW] = a;
            vecB[i*BW +: BW] = b;
        end
    endtask

    // Reset for one edge, release, and check the 9-edge latency.
    task automatic run_vec(input string nm, input logic [BW-1:0] exp);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        reset = 1'b1;
        for (int e = 1; e <= N + 1; e++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_ready_edge%0d", nm, e), {17'd0, dataReady},
                  (e == N + 1) ? 18'd1 : 18'd0);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    logic [BW-1:0] exp_ovf_pos;
    logic [BW-1:0] exp_ovf_neg;

    initial begin
`ifdef ARRAY_PROD_SATURATE_EN
        exp_ovf_pos = 18'h1FFFF;
        exp_ovf_neg = 18'h20000;
`else
        exp_ovf_pos = 18'h04000;
        exp_ovf_neg = 18'h3C000;
`endif
        reset = 1'b0;
        vecA  = '0;
        vecB  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ready", {17'd0, dataReady}, 18'd0);
        check("reset_result", result, 18'd0);

        // 1.0 * 0.5 * 8 = 4.0
        set_all(18'h00800, 18'h00400);
        run_vec("ones_half", 18'h02000);

        // -1.0 * 0.25 * 8 = -2.0
        set_all(18'h3F800, 18'h00200);
        run_vec("neg_quarter", 18'h3F000);

        // Truncation: 1 LSB * 1 LSB -> 0, -1 LSB * 1 LSB -> floor to -1 LSB
        set_all(18'h0, 18'h0);
        vecA[0 +: BW] = 18'h00001;
        vecB[0 +: BW] = 18'h00001;
        run_vec("trunc_pos", 18'h00000);
        vecA[0 +: BW] = 18'h3FFFF;
        run_vec("trunc_neg", 18'h3FFFF);

        // Per-element indexing: a_i = i+1, b = 1.0 -> 36.0
        for (int i = 0; i < N; i++) begin
            vecA[i*BW +: BW] = BW'((i + 1) * 2048);
            vecB[i*BW +: BW] = 18'h00800;
        end
        run_vec("ramp", 18'h12000);

        // Alternating b = +/-0.5 -> 0.5*(1-2+3-4+5-6+7-8) = -2.0
        for (int i = 0; i < N; i++) begin
            vecB[i*BW +: BW] = (i % 2 == 0) ? 18'h00400 : 18'h3FC00;
        end
        run_vec("ramp_alt", 18'h3F000);

        // Overflow: 31.0 * 31.0 * 8 = 7688.0, and its negative
        set_all(18'h0F800, 18'h0F800);
        run_vec("ovf_pos", exp_ovf_pos);
        set_all(18'h0F800, 18'h30800);
        run_vec("ovf_neg", exp_ovf_neg);

        // Reset asserted ahead of edge 4 of a computation
        set_all(18'h00800, 18'h00400);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort_ready", {17'd0, dataReady}, 18'd0);
        check("abort_result", result, 18'd0);
        run_vec("after_abort", 18'h02000);

        // Frozen in DONE despite input changes
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            set_all(BW'($urandom), BW'($urandom));
            @(posedge clock);
            #1;
            check($sformatf("hold_result_%0d", c), result, 18'h02000);
            check($sformatf("hold_ready_%0d", c), {17'd0, dataReady}, 18'd1);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("clear_ready", {17'd0, dataReady}, 18'd0);
        check("clear_result", result, 18'd0);

        @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", 18'(exp_q.size()), 18'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
